// File: rtl/scoreboard_slot_allocator.sv
// Scoreboard slot allocator: owns the occupancy bitmap and grants one free slot per
// cycle (0-cycle grant from registered state) while releasing at most one slot per cycle.
module scoreboard_slot_allocator #(
  parameter int WIDTH = 8,
  parameter int MODE = 0,
  localparam int IWIDTH = $clog2(WIDTH),
  localparam int CWIDTH = $clog2(WIDTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alloc_req,
  output logic              alloc_gnt,
  output logic [IWIDTH-1:0] alloc_idx,
  input  logic              free_val,
  input  logic [IWIDTH-1:0] free_idx,
  output logic [WIDTH-1:0]  occupancy,
  output logic [CWIDTH-1:0] count,
  output logic              full,
  output logic              empty,
  output logic              free_err
);

  localparam logic [CWIDTH-1:0]  LP_FULL    = CWIDTH'(WIDTH);
  localparam logic [WIDTH-1:0]   LP_ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] LP_DBL_ONE = {{(2*WIDTH-1){1'b0}}, 1'b1};

  generate
    if (MODE < 0 || MODE > 2) begin : g_badMode
      $error("scoreboard_slot_allocator: MODE must be 0, 1 or 2");
    end
  endgenerate

  logic [WIDTH-1:0]   r_occ;
  logic [CWIDTH-1:0]  r_count;
  logic               r_freeErr;
  logic [IWIDTH-1:0]  r_rrPtr;

  logic               w_full;
  logic               w_gnt;
  logic [WIDTH-1:0]   w_freeSlots;
  logic [IWIDTH-1:0]  w_idxHigh;
  logic [IWIDTH-1:0]  w_idxLow;
  logic [IWIDTH-1:0]  w_idxRr;
  logic [IWIDTH-1:0]  w_idxSel;
  logic [2*WIDTH-1:0] w_rrMask;
  logic [2*WIDTH-1:0] w_rrCand;
  logic [2*WIDTH-1:0] w_rrFirst;
  logic [WIDTH-1:0]   w_freeOneHot;
  logic               w_freeHit;
  logic [WIDTH-1:0]   w_gntOneHot;
  logic [WIDTH-1:0]   w_clrMask;

  assign w_full      = (r_count == LP_FULL);
  assign w_gnt       = alloc_req & ~w_full;
  assign w_freeSlots = ~r_occ;

  always_comb begin
    w_idxHigh = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (w_freeSlots[i]) w_idxHigh = IWIDTH'(i);
    end
  end

  always_comb begin
    w_idxLow = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (w_freeSlots[i]) w_idxLow = IWIDTH'(i);
    end
  end

  // Round-robin: mask the doubled free vector above rr_ptr, isolate the lowest set bit, fold back
  always_comb begin
    w_rrMask = '0;
    for (int j = 0; j < 2 * WIDTH; j++) begin
      w_rrMask[j] = (j > int'(r_rrPtr));
    end
  end

  assign w_rrCand  = {w_freeSlots, w_freeSlots} & w_rrMask;
  assign w_rrFirst = w_rrCand & (~w_rrCand + LP_DBL_ONE);

  always_comb begin
    w_idxRr = '0;
    for (int j = 0; j < 2 * WIDTH; j++) begin
      if (w_rrFirst[j]) w_idxRr = IWIDTH'(j % WIDTH);
    end
  end

  always_comb begin
    case (MODE)
      1:       w_idxSel = w_idxLow;
      2:       w_idxSel = w_idxRr;
      default: w_idxSel = w_idxHigh;
    endcase
  end

  // An out-of-range free_idx shifts the one-hot out entirely, so it can never hit
  assign w_freeOneHot = LP_ONE << free_idx;
  assign w_freeHit    = free_val & |(r_occ & w_freeOneHot);
  assign w_gntOneHot  = w_gnt ? (LP_ONE << w_idxSel) : '0;
  assign w_clrMask    = w_freeHit ? w_freeOneHot : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_occ     <= '0;
      r_count   <= '0;
      r_freeErr <= 1'b0;
      r_rrPtr   <= IWIDTH'(WIDTH - 1);
    end else begin
      r_occ <= (r_occ & ~w_clrMask) | w_gntOneHot;
      case ({w_gnt, w_freeHit})
        2'b10:   r_count <= r_count + CWIDTH'(1);
        2'b01:   r_count <= r_count - CWIDTH'(1);
        default: r_count <= r_count;
      endcase
      if (free_val && !w_freeHit) r_freeErr <= 1'b1;
      if (w_gnt) r_rrPtr <= w_idxSel;
    end
  end

  assign alloc_gnt = w_gnt;
  assign alloc_idx = w_gnt ? w_idxSel : '0;
  assign occupancy = r_occ;
  assign count     = r_count;
  assign full      = w_full;
  assign empty     = (r_count == '0);
  assign free_err  = r_freeErr;

endmodule

// File: tb/tb_scoreboard_slot_allocator.sv
// Bench for scoreboard_slot_allocator: one instance per selection policy, expected
// grant indices queued by the stimulus and consumed by an independent monitor.
module tb_scoreboard_slot_allocator;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       allocReq  [3];
   logic       freeVal   [3];
   logic [2:0] freeIdx   [3];
   logic       allocGnt  [3];
   logic [2:0] allocIdx  [3];
   logic [7:0] occupancy [3];
   logic [3:0] count     [3];
   logic       full      [3];
   logic       empty     [3];
   logic       freeErr   [3];

   int testsRun = 0;
   int testsFailed = 0;

   logic [2:0] q0 [$];
   logic [2:0] q1 [$];
   logic [2:0] q2 [$];

   // Free-running 10-unit clock
   always #5 clk = ~clk;

   scoreboard_slot_allocator #(.WIDTH(8), .MODE(0)) uMode0 (
      .clk(clk), .reset(reset), .alloc_req(allocReq[0]), .alloc_gnt(allocGnt[0]),
      .alloc_idx(allocIdx[0]), .free_val(freeVal[0]), .free_idx(freeIdx[0]),
      .occupancy(occupancy[0]), .count(count[0]), .full(full[0]), .empty(empty[0]),
      .free_err(freeErr[0]));

   scoreboard_slot_allocator #(.WIDTH(8), .MODE(1)) uMode1 (
      .clk(clk), .reset(reset), .alloc_req(allocReq[1]), .alloc_gnt(allocGnt[1]),
      .alloc_idx(allocIdx[1]), .free_val(freeVal[1]), .free_idx(freeIdx[1]),
      .occupancy(occupancy[1]), .count(count[1]), .full(full[1]), .empty(empty[1]),
      .free_err(freeErr[1]));

   scoreboard_slot_allocator #(.WIDTH(8), .MODE(2)) uMode2 (
      .clk(clk), .reset(reset), .alloc_req(allocReq[2]), .alloc_gnt(allocGnt[2]),
      .alloc_idx(allocIdx[2]), .free_val(freeVal[2]), .free_idx(freeIdx[2]),
      .occupancy(occupancy[2]), .count(count[2]), .full(full[2]), .empty(empty[2]),
      .free_err(freeErr[2]));

   // One comparison: logs a FAIL line with actual and required values on mismatch
   task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
      testsRun++;
      if (act !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic pushExp(int d, logic [2:0] idx);
      case (d)
         0:       q0.push_back(idx);
         1:       q1.push_back(idx);
         default: q2.push_back(idx);
      endcase
   endtask

   // Monitor side of the scoreboard: every observed grant must match the next queued index
   task automatic popCheck(int d);
      int sz;
      logic [2:0] exp;
      case (d)
         0:       sz = q0.size();
         1:       sz = q1.size();
         default: sz = q2.size();
      endcase
      testsRun++;
      if (sz == 0) begin
         testsFailed++;
         $display("[TB] FAIL grant mode%0d: got grant idx %0d, expected no grant", d, allocIdx[d]);
      end else begin
         case (d)
            0:       exp = q0.pop_front();
            1:       exp = q1.pop_front();
            default: exp = q2.pop_front();
         endcase
         if (allocIdx[d] !== exp) begin
            testsFailed++;
            $display("[TB] FAIL grant mode%0d: got idx %0d, expected %0d", d, allocIdx[d], exp);
         end
      end
   endtask

   // Grants are observed mid-cycle; grants shown while reset is high are never recorded
   always @(negedge clk) begin
      if (reset === 1'b0) begin
         for (int d = 0; d < 3; d++) begin
            if (allocGnt[d] === 1'b1) popCheck(d);
         end
      end
   end

   // Drives one cycle of inputs on one instance and parks at the following negedge
   task automatic applyStimulus(int d, logic req, logic fv, logic [2:0] fi,
                                logic expGnt, logic [2:0] expIdx);
      @(posedge clk);
      #1;
      reset = 1'b0;
      for (int k = 0; k < 3; k++) begin
         allocReq[k] = 1'b0;
         freeVal[k]  = 1'b0;
         freeIdx[k]  = 3'd0;
      end
      allocReq[d] = req;
      freeVal[d]  = fv;
      freeIdx[d]  = fi;
      if (expGnt) pushExp(d, expIdx);
      @(negedge clk);
   endtask

   task automatic applyReset(int d, logic req);
      @(posedge clk);
      #1;
      reset = 1'b1;
      for (int k = 0; k < 3; k++) begin
         allocReq[k] = 1'b0;
         freeVal[k]  = 1'b0;
         freeIdx[k]  = 3'd0;
      end
      allocReq[d] = req;
      @(negedge clk);
   endtask

   task automatic checkOutput(int d, string name, int expCount, logic [7:0] expOcc, logic expErr);
      cmp({name, ".count"}, 32'(count[d]), 32'(expCount));
      cmp({name, ".occupancy"}, 32'(occupancy[d]), 32'(expOcc));
      cmp({name, ".full"}, 32'(full[d]), 32'(expCount == 8));
      cmp({name, ".empty"}, 32'(empty[d]), 32'(expCount == 0));
      cmp({name, ".free_err"}, 32'(freeErr[d]), 32'(expErr));
   endtask

   task automatic checkGnt(int d, string name, logic exp);
      cmp(name, 32'(allocGnt[d]), 32'(exp));
   endtask

   logic [7:0] expOcc;

   // Directed scenarios, one policy at a time, each starting from reset
   initial begin
      for (int k = 0; k < 3; k++) begin
         allocReq[k] = 1'b0;
         freeVal[k]  = 1'b0;
         freeIdx[k]  = 3'd0;
      end

      applyReset(0, 1'b0);
      applyStimulus(0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0);
      for (int d = 0; d < 3; d++) checkOutput(d, "reset", 0, 8'h00, 1'b0);

      // MODE 0: burst of nine requests, highest free slot first
      expOcc = 8'h00;
      for (int k = 0; k < 8; k++) begin
         applyStimulus(0, 1'b1, 1'b0, 3'd0, 1'b1, 3'(7 - k));
         checkOutput(0, "m0burst", k, expOcc, 1'b0);
         expOcc[7 - k] = 1'b1;
      end
      applyStimulus(0, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0);
      checkGnt(0, "m0ninthGnt", 1'b0);
      checkOutput(0, "m0full", 8, 8'hFF, 1'b0);

      // Full with a same-cycle free: no grant until the next cycle
      applyStimulus(0, 1'b1, 1'b1, 3'd4, 1'b0, 3'd0);
      checkGnt(0, "m0fullFreeGnt", 1'b0);
      checkOutput(0, "m0fullFree", 8, 8'hFF, 1'b0);
      applyStimulus(0, 1'b1, 1'b0, 3'd0, 1'b1, 3'd4);
      checkGnt(0, "m0refillGnt", 1'b1);
      checkOutput(0, "m0refill", 7, 8'hEF, 1'b0);
      applyStimulus(0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0);
      checkOutput(0, "m0refilled", 8, 8'hFF, 1'b0);

      // Invalid free: sticky error, state untouched, cleared only by reset
      applyReset(0, 1'b0);
      applyStimulus(0, 1'b0, 1'b1, 3'd5, 1'b0, 3'd0);
      checkOutput(0, "badFreeCycle", 0, 8'h00, 1'b0);
      applyStimulus(0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0);
      checkOutput(0, "badFreeSet", 0, 8'h00, 1'b1);
      applyStimulus(0, 1'b1, 1'b0, 3'd0, 1'b1, 3'd7);
      checkOutput(0, "badFreeHeld", 0, 8'h00, 1'b1);
      applyReset(0, 1'b0);
      applyStimulus(0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0);
      checkOutput(0, "errCleared", 0, 8'h00, 1'b0);

      // Reset landing mid-burst with a request still asserted
      applyStimulus(0, 1'b1, 1'b0, 3'd0, 1'b1, 3'd7);
      applyStimulus(0, 1'b1, 1'b0, 3'd0, 1'b1, 3'd6);
      applyReset(0, 1'b1);
      applyStimulus(0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0);
      checkOutput(0, "midReset", 0, 8'h00, 1'b0);
      applyStimulus(0, 1'b1, 1'b0, 3'd0, 1'b1, 3'd7);
      checkOutput(0, "postReset", 0, 8'h00, 1'b0);

      // MODE 1: lowest free slot, freed slot reused, simultaneous grant and free
      applyReset(1, 1'b0);
      applyStimulus(1, 1'b1, 1'b0, 3'd0, 1'b1, 3'd0);
      applyStimulus(1, 1'b1, 1'b0, 3'd0, 1'b1, 3'd1);
      applyStimulus(1, 1'b1, 1'b0, 3'd0, 1'b1, 3'd2);
      applyStimulus(1, 1'b0, 1'b1, 3'd1, 1'b0, 3'd0);
      checkOutput(1, "m1three", 3, 8'h07, 1'b0);
      applyStimulus(1, 1'b1, 1'b0, 3'd0, 1'b1, 3'd1);
      checkOutput(1, "m1afterFree", 2, 8'h05, 1'b0);
      applyStimulus(1, 1'b1, 1'b1, 3'd0, 1'b1, 3'd3);
      checkOutput(1, "m1realloc", 3, 8'h07, 1'b0);
      applyStimulus(1, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0);
      checkOutput(1, "m1swap", 3, 8'h0E, 1'b0);

      // MODE 2: round-robin continues past a freed low slot
      applyReset(2, 1'b0);
      applyStimulus(2, 1'b1, 1'b0, 3'd0, 1'b1, 3'd0);
      applyStimulus(2, 1'b1, 1'b0, 3'd0, 1'b1, 3'd1);
      applyStimulus(2, 1'b1, 1'b0, 3'd0, 1'b1, 3'd2);
      applyStimulus(2, 1'b0, 1'b1, 3'd0, 1'b0, 3'd0);
      checkOutput(2, "m2three", 3, 8'h07, 1'b0);
      applyStimulus(2, 1'b1, 1'b0, 3'd0, 1'b1, 3'd3);
      checkOutput(2, "m2skip", 2, 8'h06, 1'b0);
      applyStimulus(2, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0);
      checkOutput(2, "m2afterSkip", 3, 8'h0E, 1'b0);

      // MODE 2: fill to 8'h7F (rr_ptr=6), take slot 7, then wrap after a free
      applyReset(2, 1'b0);
      for (int k = 0; k < 7; k++) applyStimulus(2, 1'b1, 1'b0, 3'd0, 1'b1, 3'(k));
      applyStimulus(2, 1'b1, 1'b0, 3'd0, 1'b1, 3'd7);
      checkOutput(2, "m2seven", 7, 8'h7F, 1'b0);
      applyStimulus(2, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0);
      checkGnt(2, "m2fullGnt", 1'b0);
      checkOutput(2, "m2full", 8, 8'hFF, 1'b0);
      applyStimulus(2, 1'b0, 1'b1, 3'd2, 1'b0, 3'd0);
      applyStimulus(2, 1'b1, 1'b0, 3'd0, 1'b1, 3'd2);
      checkOutput(2, "m2wrap", 7, 8'hFB, 1'b0);
      applyStimulus(2, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0);
      checkOutput(2, "m2wrapped", 8, 8'hFF, 1'b0);

      // Every queued grant must have been observed
      applyStimulus(0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0);
      cmp("pendingMode0", 32'(q0.size()), 32'd0);
      cmp("pendingMode1", 32'(q1.size()), 32'd0);
      cmp("pendingMode2", 32'(q2.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
